// File: rtl/ncl_sum_capture.sv
// NCL-to-synchronous capture stage: detects dual-rail DATA/NULL wavefronts, acknowledges upstream,
// and buffers each DATA word on a valid/ready port. Optional NCL_SUM_SEQ_CHECK_EN adds a +1 sequence checker.
module ncl_sum_capture #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           init_n,
    input  logic [2*W-1:0] sum_dr,
    output logic           sum_ack,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           dr_err
`ifdef NCL_SUM_SEQ_CHECK_EN
    ,
    output logic           seq_err
`endif
);

    typedef enum logic {
        WAIT_NULL = 1'b0,
        WAIT_DATA = 1'b1
    } state_t;

    logic [W-1:0] digit_data;
    logic [W-1:0] digit_both;
    logic [W-1:0] true_rail;
    logic         all_data;
    logic         all_null;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_digit
            assign digit_data[gi] = sum_dr[2*gi+1] | sum_dr[2*gi];
            assign digit_both[gi] = sum_dr[2*gi+1] & sum_dr[2*gi];
            assign true_rail[gi]  = sum_dr[2*gi+1];
        end
    endgenerate

    assign all_data = &digit_data;
    assign all_null = ~|sum_dr;

    // Completeness flags cross from the self-timed domain, so only their synchronized copies steer the FSM.
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic [SYNC_STAGES-1:0] null_sync_reg;
    logic                   data_s;
    logic                   null_s;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            data_sync_reg <= '0;
            null_sync_reg <= '0;
        end else begin
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], all_data};
            null_sync_reg <= {null_sync_reg[SYNC_STAGES-2:0], all_null};
        end
    end

    assign data_s = data_sync_reg[SYNC_STAGES-1];
    assign null_s = null_sync_reg[SYNC_STAGES-1];

    state_t       state_reg, state_next;
    logic         sum_ack_reg, sum_ack_next;
    logic [W-1:0] out_data_reg, out_data_next;
    logic         out_valid_reg, out_valid_next;
    logic         dr_err_reg, dr_err_next;
    logic         capture;

`ifdef NCL_SUM_SEQ_CHECK_EN
    logic [W-1:0] last_word_reg, last_word_next;
    logic         ref_valid_reg, ref_valid_next;
    logic         seq_err_reg, seq_err_next;
`endif

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_reg     <= WAIT_NULL;
            sum_ack_reg   <= 1'b1;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            dr_err_reg    <= 1'b0;
`ifdef NCL_SUM_SEQ_CHECK_EN
            last_word_reg <= '0;
            ref_valid_reg <= 1'b0;
            seq_err_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            sum_ack_reg   <= sum_ack_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            dr_err_reg    <= dr_err_next;
`ifdef NCL_SUM_SEQ_CHECK_EN
            last_word_reg <= last_word_next;
            ref_valid_reg <= ref_valid_next;
            seq_err_reg   <= seq_err_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        sum_ack_next   = sum_ack_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        dr_err_next    = dr_err_reg;
        capture        = 1'b0;
`ifdef NCL_SUM_SEQ_CHECK_EN
        last_word_next = last_word_reg;
        ref_valid_next = ref_valid_reg;
        seq_err_next   = seq_err_reg;
`endif

        case (state_reg)
            WAIT_NULL: begin
                if (null_s) begin
                    sum_ack_next = 1'b0;
                    state_next   = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // A full buffer that is not draining leaves sum_ack low, stalling the NCL pipeline.
                if (data_s && (!out_valid_reg || out_ready)) begin
                    capture      = 1'b1;
                    sum_ack_next = 1'b1;
                    state_next   = WAIT_NULL;
                end
            end
            default: state_next = WAIT_NULL;
        endcase

        if (capture) begin
            out_data_next  = true_rail;
            out_valid_next = 1'b1;
            if (|digit_both) begin
                dr_err_next = 1'b1;
            end
`ifdef NCL_SUM_SEQ_CHECK_EN
            if (ref_valid_reg && (true_rail != (last_word_reg + {{(W-1){1'b0}}, 1'b1}))) begin
                seq_err_next = 1'b1;
            end
            last_word_next = true_rail;
            ref_valid_next = 1'b1;
`endif
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    assign sum_ack   = sum_ack_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign dr_err    = dr_err_reg;
`ifdef NCL_SUM_SEQ_CHECK_EN
    assign seq_err   = seq_err_reg;
`endif

endmodule

// File: doc/ncl_sum_capture.md
Name: ncl_sum_capture

Overview:
- Downstream consumer of the 32-digit dual-rail NCL counter.
- Replaces the counter's auto-consume sum completion with a real acknowledge: observes the dual-rail sum vector, detects DATA/NULL wavefront completeness, and latches each DATA wavefront into a clocked single-rail register.
- Returns an NCL-style acknowledge upstream and presents the captured word on a valid/ready interface.
- Forms the NCL-to-synchronous boundary of the counter sandbox.

Parameters:
- W, 32, number of dual-rail digits (output word width).
- SYNC_STAGES, 2, flop depth of each completeness synchronizer (min 2).

Ports:
- clk  input  1  capture clock.
- init_n  input  1  asynchronous active-low reset.
- sum_dr  input  2*W  dual-rail sum, digit k: bit 2k+1 = TRUE rail, bit 2k = FALSE rail.
- sum_ack  output  1  completion to upstream: 1 = request NULL, 0 = request DATA.
- out_data  output  W  captured single-rail word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts word when out_valid & out_ready at clk edge.
- dr_err  output  1  sticky: a captured digit had both rails high.

Behaviour:
- Reset (init_n low, async): state=WAIT_NULL, sum_ack=1, out_valid=0, out_data=0, dr_err=0, synchronizer flops=0.
- Combinational detect on sum_dr:
  - all_data = every digit has at least one rail high.
  - all_null = every rail low.
  - Mixed vectors assert neither.
- all_data and all_null each pass through SYNC_STAGES flops; FSM uses only the synchronized versions (data_s, null_s).
- sum_dr is sampled directly at capture. This is safe because upstream holds DATA stable until sum_ack rises.
- FSM:
  - WAIT_NULL: when null_s=1 -> sum_ack<=0, go WAIT_DATA.
  - WAIT_DATA: when data_s=1 and (out_valid=0 or out_ready=1), capture:
    - out_data[k]<=sum_dr[2k+1]
    - out_valid<=1
    - sum_ack<=1
    - go WAIT_NULL
  - WAIT_DATA with data_s=1 but buffer full and not draining: hold, no capture, sum_ack stays 0 (backpressure stalls the NCL pipeline).
- Output buffer:
  - out_valid clears on out_valid & out_ready unless a capture happens in the same cycle.
  - Simultaneous drain and capture: out_valid stays 1 with the new word.
- Latency: sum_dr reaching full DATA -> out_valid high = SYNC_STAGES+1 clk edges (3 by default). Full NULL -> sum_ack low = SYNC_STAGES+1 edges.
- dr_err: set at capture if any digit has 11; cleared only by reset. The bit still takes the TRUE rail.
- No capture ever happens in WAIT_NULL, even if DATA reappears before NULL is seen.
- Reset mid-handshake: returns to WAIT_NULL with sum_ack=1, so the upstream flushes to NULL before the next capture. A partially observed wavefront is discarded.

Optional Feature:
- Macro: NCL_SUM_SEQ_CHECK_EN.
- Defined:
  - Adds output seq_err (1 bit, sticky, reset 0) and an internal last-word register.
  - From the second capture on, seq_err sets if the captured word != previous word + 1 mod 2^W.
  - Wrap 0xFFFFFFFF -> 0x00000000 is legal.
  - The first capture after reset only loads the reference.
- Not defined: port and logic absent; module behaves identically otherwise.

Test Plan:
- Reset with sum_dr all NULL -> after release, sum_ack falls on the 3rd clk edge; out_valid=0, dr_err=0.
- Drive DATA encoding 0x0000002A with out_ready=1 -> out_data=0x0000002A, out_valid=1 on 3rd edge; sum_ack=1. Drive NULL -> sum_ack=0 three edges later.
- Hold out_ready=0, complete two wavefronts (5 then 6) -> first captured, second stalled with sum_ack=0. Raise out_ready -> 5 drained and 6 captured on the same edge, out_valid stays 1.
- Mixed vector (half digits DATA, half NULL) held 10 cycles -> no capture, sum_ack unchanged. Completing the vector -> capture.
- Digit 3 driven 11 in an otherwise valid wavefront -> dr_err=1 and stays 1 across later clean captures until init_n pulse.
- With NCL_SUM_SEQ_CHECK_EN: feed 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 -> seq_err=0. Then feed 0x00000002 -> seq_err=1.
